// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S receive master generating SCK/WS and deserialising SD into PCM words.
// Define MONO_LEFT_EN to publish only left-slot words.
module i2s_rx_master #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                i2s_sck,
  output logic                i2s_ws,
  input  logic                i2s_sd,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                overrun_clr
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(SLOT_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 1);
  localparam logic [BW-1:0] K_LAST   = BW'(SAMPLE_W);
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                sck_q, sck_d, ws_q, ws_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d, data_q, data_d;
  logic                pend_q, pend_d, pend_right_q, pend_right_d;
  logic                right_q, right_d, valid_q, valid_d, ovr_q, ovr_d;
  logic                tick, rise, fall, capture, keep, load, drop;
  always_comb begin
    tick         = div_cnt_q == DIV_LAST;
    rise         = tick && !sck_q;
    fall         = tick && sck_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    sck_d        = sck_q ^ tick;
    bit_cnt_d    = fall ? (bit_cnt_q == BIT_LAST ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
    ws_d         = ws_q ^ (fall && bit_cnt_q == BIT_LAST);
    // bit 0 of each slot is the I2S one-bit delay and is never captured
    capture      = rise && bit_cnt_q != '0 && bit_cnt_q <= K_LAST;
    shift_d      = capture ? {shift_q[SAMPLE_W-2:0], i2s_sd} : shift_q;
    pend_d       = rise && bit_cnt_q == K_LAST;
    pend_right_d = ws_q;
`ifdef MONO_LEFT_EN
    keep         = pend_q && !pend_right_q;
    right_d      = 1'b0;
`else
    keep         = pend_q;
    right_d      = (keep && (!valid_q || sample_ready)) ? pend_right_q : right_q;
`endif
    load         = keep && (!valid_q || sample_ready);
    drop         = keep && valid_q && !sample_ready;
    data_d       = load ? shift_q : data_q;
    valid_d      = load || (valid_q && !sample_ready);
    ovr_d        = drop || (ovr_q && !overrun_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      shift_q      <= '0;
      pend_q       <= 1'b0;
      pend_right_q <= 1'b0;
      data_q       <= '0;
      right_q      <= 1'b0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_right_q <= pend_right_d;
      data_q       <= data_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end
  assign i2s_sck      = sck_q;
  assign i2s_ws       = ws_q;
  assign sample_data  = data_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
endmodule
